// File: rtl/seg7_scan.sv
// Six-digit multiplexed 7-segment scanner for an HH:MM:SS display.
// The BCD digits are latched once per frame, and each slot begins with a blanked dead cycle.
module seg7_scan #(
    parameter int CLK_DIV = 1000
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic        enable,
    input  logic [23:0] digits,
    input  logic        blank_lead,
    input  logic [5:0]  dp_mask,
    output logic [6:0]  seg,
    output logic [5:0]  an,
    output logic        dp,
    output logic        frame_tick
);

    localparam int PW = $clog2(CLK_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);

    logic [PW-1:0] presc;
    logic [2:0]    idx;
    logic [23:0]   snap;
    logic          slot_end;
    logic          frame_end;

    assign slot_end  = (presc == PRESC_MAX);
    assign frame_end = slot_end && (idx == 3'd5);

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            presc      <= '0;
            idx        <= '0;
            snap       <= '0;
            frame_tick <= 1'b0;
        end else if (!enable) begin
            // While idle, track the digits so scanning resumes with current values
            presc      <= '0;
            idx        <= '0;
            frame_tick <= 1'b0;
            snap       <= digits;
        end else begin
            frame_tick <= frame_end;
            if (slot_end) begin
                presc <= '0;
                idx   <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
            end else begin
                presc <= presc + 1'b1;
            end
            if (frame_end)
                snap <= digits;
        end
    end

    logic       dark;
    logic [3:0] nib;
    logic       dp_sel;
    logic [6:0] glyph;

    assign dark = !enable || (presc == '0);

    always_comb begin
        nib    = 4'h0;
        dp_sel = 1'b0;
        case (idx)
            3'd0: begin nib = snap[3:0];   dp_sel = dp_mask[0]; end
            3'd1: begin nib = snap[7:4];   dp_sel = dp_mask[1]; end
            3'd2: begin nib = snap[11:8];  dp_sel = dp_mask[2]; end
            3'd3: begin nib = snap[15:12]; dp_sel = dp_mask[3]; end
            3'd4: begin nib = snap[19:16]; dp_sel = dp_mask[4]; end
            3'd5: begin nib = snap[23:20]; dp_sel = dp_mask[5]; end
            default: begin nib = 4'h0; dp_sel = 1'b0; end
        endcase
    end

    always_comb begin
        case (nib)
            4'd0:    glyph = 7'h3F;
            4'd1:    glyph = 7'h06;
            4'd2:    glyph = 7'h5B;
            4'd3:    glyph = 7'h4F;
            4'd4:    glyph = 7'h66;
            4'd5:    glyph = 7'h6D;
            4'd6:    glyph = 7'h7D;
            4'd7:    glyph = 7'h07;
            4'd8:    glyph = 7'h7F;
            4'd9:    glyph = 7'h6F;
            default: glyph = 7'h40;
        endcase
    end

    always_comb begin
        an  = 6'b111111;
        seg = 7'h00;
        dp  = 1'b0;
        if (!dark) begin
            an  = ~(6'b000001 << idx);
            dp  = dp_sel;
            // Leading hours-tens zero is suppressed on request
            seg = (idx == 3'd5 && blank_lead && snap[23:20] == 4'h0) ? 7'h00 : glyph;
        end
    end

endmodule

// File: tb/tb_seg7_scan.sv
// Bench for seg7_scan: a cycle-count reference model plus directed and random stimulus.
module tb_seg7_scan;
    localparam int CD = 4;

    logic        clk_in = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic [23:0] digits = 24'h0;
    logic        blank_lead = 1'b0;
    logic [5:0]  dp_mask = 6'h0;
    logic [6:0]  seg;
    logic [5:0]  an;
    logic        dp;
    logic        frame_tick;

    int n_assert = 0;
    int n_fail = 0;

    // Reference state: cycles since scanning started, frame snapshot, pulse
    int          t = 0;
    logic [23:0] m_snap = 24'h0;
    logic        m_ft = 1'b0;

    seg7_scan #(.CLK_DIV(CD)) dut (
        .clk_in(clk_in), .reset(reset), .enable(enable), .digits(digits),
        .blank_lead(blank_lead), .dp_mask(dp_mask), .seg(seg), .an(an),
        .dp(dp), .frame_tick(frame_tick)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [6:0] dec(input logic [3:0] n);
        logic [6:0] tbl [10];
        tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        return (n > 4'd9) ? 7'h40 : tbl[n];
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h (t=%0d)", tag, obs, exp, t);
        end
    endtask

    function automatic int m_idx();
        return (t / CD) % 6;
    endfunction

    function automatic int m_presc();
        return t % CD;
    endfunction

    task automatic model_reset();
        t = 0; m_snap = 24'h0; m_ft = 1'b0;
    endtask

    task automatic model_edge();
        if (!reset) begin
            model_reset();
        end else if (!enable) begin
            t = 0; m_ft = 1'b0; m_snap = digits;
        end else begin
            m_ft = (t % (6 * CD)) == (6 * CD - 1);
            if (m_ft) m_snap = digits;
            t++;
        end
    endtask

    task automatic check_all();
        logic       dark;
        logic [5:0] an_e;
        logic [6:0] seg_e;
        logic       dp_e;
        logic [3:0] nib;
        int         i;
        i     = m_idx();
        dark  = !enable || m_presc() == 0;
        nib   = m_snap[i*4 +: 4];
        an_e  = dark ? 6'h3F : ~(6'b1 << i);
        seg_e = (dark || (i == 5 && blank_lead && nib == 4'h0)) ? 7'h00 : dec(nib);
        dp_e  = dark ? 1'b0 : dp_mask[i];
        chk("an", {2'b0, an}, {2'b0, an_e});
        chk("seg", {1'b0, seg}, {1'b0, seg_e});
        chk("dp", {7'b0, dp}, {7'b0, dp_e});
        chk("frame_tick", {7'b0, frame_tick}, {7'b0, m_ft});
    endtask

    task automatic step();
        @(posedge clk_in);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic async_reset_check();
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        chk("rst_an", {2'b0, an}, 8'h3F);
        chk("rst_seg", {1'b0, seg}, 8'h00);
        chk("rst_dp", {7'b0, dp}, 8'h00);
        chk("rst_ft", {7'b0, frame_tick}, 8'h00);
        step();
        reset = 1'b1;
    endtask

    int lit [6];
    int ticks;

    initial begin
        // Reset state
        #1;
        check_all();
        chk("reset_an", {2'b0, an}, 8'h3F);
        #10;
        reset = 1'b1;

        // Scan check at CLK_DIV=4
        digits = 24'h123456;
        step(); step();
        enable = 1'b1;
        #1;
        chk("enable_dead", {2'b0, an}, 8'h3F);
        ticks = 0;
        for (int k = 0; k < 6; k++) lit[k] = 0;
        for (int k = 1; k <= 24; k++) begin
            step();
            for (int p = 0; p < 6; p++)
                if (an == ~(6'b1 << p)) lit[p]++;
            if (frame_tick) ticks++;
            if (k == 1) begin
                chk("idx0_an", {2'b0, an}, 8'h3E);
                chk("idx0_seg", {1'b0, seg}, 8'h7D);
            end
            if (k == 5)  chk("idx1_seg", {1'b0, seg}, 8'h6D);
            if (k == 21) begin
                chk("idx5_an", {2'b0, an}, 8'h1F);
                chk("idx5_seg", {1'b0, seg}, 8'h06);
            end
        end
        for (int p = 0; p < 6; p++) chk("lit_cycles", 8'(lit[p]), 8'd3);
        chk("ticks_per_frame", 8'(ticks), 8'd1);

        // Snapshot: clear digits mid-frame at idx2
        repeat (9) step();
        digits = 24'h000000;
        repeat (12) step();
        chk("snap_idx5_old", {1'b0, seg}, 8'h06);
        repeat (4) step();
        chk("snap_idx0_new", {1'b0, seg}, 8'h3F);
        repeat (20) step();

        // Blanking
        digits = 24'h012345; blank_lead = 1'b1;
        repeat (48) step();
        blank_lead = 1'b0;
        repeat (24) step();
        digits = 24'h01234A;
        repeat (48) step();

        // Decimal point
        dp_mask = 6'b000100;
        repeat (24) step();
        dp_mask = 6'b000000;

        // Disable at idx3, then re-enable
        while (m_idx() != 3) step();
        step();
        enable = 1'b0;
        step();
        chk("dis_an", {2'b0, an}, 8'h3F);
        chk("dis_seg", {1'b0, seg}, 8'h00);
        digits = 24'h987650;
        step();
        enable = 1'b1;
        repeat (30) step();

        // Async reset mid-frame
        repeat (7) step();
        async_reset_check();
        repeat (30) step();

        // Random traffic
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(7) == 0) digits = 24'($urandom);
            if ($urandom_range(7) == 0) dp_mask = 6'($urandom);
            if ($urandom_range(15) == 0) blank_lead = ~blank_lead;
            if (enable ? ($urandom_range(59) == 0) : ($urandom_range(3) == 0))
                enable = ~enable;
            if ($urandom_range(299) == 0) async_reset_check();
            else step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
